// File: rtl/mem_bus_responder_if.sv
// Byte-wide CPU memory bus plus the UART streaming handshakes served by mem_bus_responder.
interface mem_bus_responder_if;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;

  modport slave (
    input  rdy_in, mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, program_stop
  );

  modport master (
    output rdy_in, mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, program_stop
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Slave side of the CPU byte bus: byte RAM, UART TX/RX FIFOs, cycle counter with
// little-endian snapshot readout, and the sticky program-stop flag.
module mem_bus_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input logic                clk_in,
  input logic                rst_in,
  mem_bus_responder_if.slave bus
);

  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam logic [TXW:0]   TX_FULL    = (TXW + 1)'(TX_DEPTH);
  localparam logic [TXW:0]   TX_HIGH    = (TXW + 1)'(TX_DEPTH - 2);
  localparam logic [TXW:0]   TX_ZERO    = {(TXW + 1){1'b0}};
  localparam logic [TXW:0]   TX_CNT_ONE = (TXW + 1)'(32'd1);
  localparam logic [TXW-1:0] TX_PTR_ONE = TXW'(32'd1);
  localparam logic [RXW:0]   RX_FULL    = (RXW + 1)'(RX_DEPTH);
  localparam logic [RXW:0]   RX_ZERO    = {(RXW + 1){1'b0}};
  localparam logic [RXW:0]   RX_CNT_ONE = (RXW + 1)'(32'd1);
  localparam logic [RXW-1:0] RX_PTR_ONE = RXW'(32'd1);

  logic [7:0]            ram_q [2**ADDR_WIDTH];
  logic [7:0]            tx_mem_q [TX_DEPTH];
  logic [TXW-1:0]        tx_wr_q, tx_rd_q;
  logic [TXW:0]          tx_count_q, tx_count_d;
  logic [7:0]            rx_mem_q [RX_DEPTH];
  logic [RXW-1:0]        rx_wr_q, rx_rd_q;
  logic [RXW:0]          rx_count_q, rx_count_d;
  logic [31:0]           cycle_q, snap_q;
  logic [7:0]            mem_din_q, mem_din_d;
  logic                  io_full_q, stop_q;

  logic [ADDR_WIDTH-1:0] ram_addr_s;
  logic                  is_io_s, ram_we_s, stop_set_s, snap_load_s;
  logic                  tx_push_req_s, tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic [7:0]            tx_push_data_s, io_rd_data_s;
  logic                  unused_s;

  assign unused_s = ^bus.mem_a[31:18];

  // Bus cycle decode into RAM write, TX push, RX pop and snapshot load.
  always_comb begin
    is_io_s        = (bus.mem_a[17:16] == 2'b11);
    ram_addr_s     = bus.mem_a[ADDR_WIDTH-1:0];
    ram_we_s       = bus.rdy_in && bus.mem_wr && !is_io_s;
    tx_push_req_s  = 1'b0;
    tx_push_data_s = bus.mem_dout;
    stop_set_s     = 1'b0;
    rx_pop_s       = 1'b0;
    snap_load_s    = 1'b0;
    if (bus.rdy_in && is_io_s) begin
      if (bus.mem_wr) begin
        if (bus.mem_a[2]) begin
          tx_push_req_s  = 1'b1;
          tx_push_data_s = 8'h00;
          stop_set_s     = 1'b1;
        end else begin
          tx_push_req_s = (bus.mem_dout != 8'h00);
        end
      end else begin
        // An empty RX FIFO is never popped, even if a byte arrives this same edge.
        rx_pop_s    = !bus.mem_a[2] && (rx_count_q != RX_ZERO);
        snap_load_s = bus.mem_a[2] && (bus.mem_a[1:0] == 2'b00);
      end
    end else begin
      tx_push_req_s = 1'b0;
    end
  end

  // Read data selection; mem_din only changes on an enabled read cycle.
  always_comb begin
    io_rd_data_s = 8'h00;
    if (!bus.mem_a[2]) begin
      io_rd_data_s = (rx_count_q != RX_ZERO) ? rx_mem_q[rx_rd_q] : 8'h00;
    end else begin
      case (bus.mem_a[1:0])
        2'b00:   io_rd_data_s = cycle_q[7:0];
        2'b01:   io_rd_data_s = snap_q[15:8];
        2'b10:   io_rd_data_s = snap_q[23:16];
        2'b11:   io_rd_data_s = snap_q[31:24];
        default: io_rd_data_s = 8'h00;
      endcase
    end
    if (bus.rdy_in && !bus.mem_wr) begin
      mem_din_d = is_io_s ? io_rd_data_s : ram_q[ram_addr_s];
    end else begin
      mem_din_d = mem_din_q;
    end
  end

  assign tx_pop_s  = (tx_count_q != TX_ZERO) && bus.tx_ready;
  assign tx_push_s = tx_push_req_s && ((tx_count_q != TX_FULL) || tx_pop_s);
  assign rx_push_s = bus.rx_valid && (rx_count_q != RX_FULL);

  // FIFO occupancy next state.
  always_comb begin
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_count_d = tx_count_q + TX_CNT_ONE;
      2'b01:   tx_count_d = tx_count_q - TX_CNT_ONE;
      default: tx_count_d = tx_count_q;
    endcase
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_count_d = rx_count_q + RX_CNT_ONE;
      2'b01:   rx_count_d = rx_count_q - RX_CNT_ONE;
      default: rx_count_d = rx_count_q;
    endcase
  end

  // Byte RAM; contents deliberately survive reset.
  always_ff @(posedge clk_in) begin
    if (ram_we_s) begin
      ram_q[ram_addr_s] <= bus.mem_dout;
    end
  end

  // All resettable bus-side and UART-side state.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= 8'h00;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= 8'h00;
      tx_wr_q    <= {TXW{1'b0}};
      tx_rd_q    <= {TXW{1'b0}};
      tx_count_q <= TX_ZERO;
      rx_wr_q    <= {RXW{1'b0}};
      rx_rd_q    <= {RXW{1'b0}};
      rx_count_q <= RX_ZERO;
      cycle_q    <= 32'd0;
      snap_q     <= 32'd0;
      mem_din_q  <= 8'h00;
      io_full_q  <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      if (tx_push_s) begin
        tx_mem_q[tx_wr_q] <= tx_push_data_s;
        tx_wr_q           <= tx_wr_q + TX_PTR_ONE;
      end
      if (tx_pop_s) begin
        tx_rd_q <= tx_rd_q + TX_PTR_ONE;
      end
      if (rx_push_s) begin
        rx_mem_q[rx_wr_q] <= bus.rx_data;
        rx_wr_q           <= rx_wr_q + RX_PTR_ONE;
      end
      if (rx_pop_s) begin
        rx_rd_q <= rx_rd_q + RX_PTR_ONE;
      end
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      if (bus.rdy_in) begin
        cycle_q <= cycle_q + 32'd1;
      end
      if (snap_load_s) begin
        snap_q <= cycle_q;
      end
      mem_din_q <= mem_din_d;
      io_full_q <= (tx_count_d >= TX_HIGH);
      if (stop_set_s) begin
        stop_q <= 1'b1;
      end
    end
  end

  assign bus.mem_din        = mem_din_q;
  assign bus.io_buffer_full = io_full_q;
  assign bus.tx_data        = tx_mem_q[tx_rd_q];
  assign bus.tx_valid       = (tx_count_q != TX_ZERO);
  assign bus.rx_ready       = (rx_count_q != RX_FULL);
  assign bus.program_stop   = stop_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: RAM, TX filter/backpressure, RX, counter, freeze, reset.
module tb_mem_bus_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cnt_model = 0;
  logic [31:0] exp_cnt;
  logic [7:0]  snap_b [4];
  logic [7:0]  exp_tx [8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};

  mem_bus_responder_if bus_if ();

  mem_bus_responder #(
    .ADDR_WIDTH(17),
    .TX_DEPTH  (8),
    .RX_DEPTH  (8)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus_if.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    bus_if.rdy_in   = 1'b1;
    bus_if.mem_wr   = 1'b1;
    bus_if.mem_a    = a;
    bus_if.mem_dout = d;
    @(posedge clk_in);
    #1;
    bus_if.rdy_in = 1'b0;
    cnt_model++;
  endtask

  task automatic bus_rd(input logic [31:0] a);
    bus_if.rdy_in = 1'b1;
    bus_if.mem_wr = 1'b0;
    bus_if.mem_a  = a;
    @(posedge clk_in);
    #1;
    bus_if.rdy_in = 1'b0;
    cnt_model++;
  endtask

  task automatic idle();
    bus_if.rdy_in = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_mem_din"}, {24'd0, bus_if.mem_din}, 32'h00);
    check_eq({pfx, "_iofull"}, {31'd0, bus_if.io_buffer_full}, 32'd0);
    check_eq({pfx, "_tx_valid"}, {31'd0, bus_if.tx_valid}, 32'd0);
    check_eq({pfx, "_tx_data"}, {24'd0, bus_if.tx_data}, 32'h00);
    check_eq({pfx, "_rx_ready"}, {31'd0, bus_if.rx_ready}, 32'd1);
    check_eq({pfx, "_stop"}, {31'd0, bus_if.program_stop}, 32'd0);
  endtask

  initial begin
    rst_in          = 1'b1;
    bus_if.rdy_in   = 1'b0;
    bus_if.mem_wr   = 1'b0;
    bus_if.mem_a    = 32'd0;
    bus_if.mem_dout = 8'h00;
    bus_if.tx_ready = 1'b0;
    bus_if.rx_data  = 8'h00;
    bus_if.rx_valid = 1'b0;
    #2 rst_in = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in    = 1'b1;
    cnt_model = 0;

    // RAM write/read and address aliasing
    bus_wr(32'h0001_0010 & 32'h0000_FFFF, 8'hA5);
    bus_rd(32'h0000_0010);
    check_eq("ram_rd", {24'd0, bus_if.mem_din}, 32'hA5);
    bus_wr(32'h0002_0010, 8'h3C);
    bus_rd(32'h0000_0010);
    check_eq("ram_alias_wr", {24'd0, bus_if.mem_din}, 32'h3C);
    bus_wr(32'h0000_0011, 8'h5A);
    bus_rd(32'h0002_0011);
    check_eq("ram_alias_rd", {24'd0, bus_if.mem_din}, 32'h5A);

    // TX zero filter and program stop
    bus_wr(32'h0003_0000, 8'h48);
    check_eq("tx_first_valid", {31'd0, bus_if.tx_valid}, 32'd1);
    check_eq("tx_first_data", {24'd0, bus_if.tx_data}, 32'h48);
    check_eq("stop_before", {31'd0, bus_if.program_stop}, 32'd0);
    bus_wr(32'h0003_0000, 8'h00);
    bus_wr(32'h0003_0000, 8'h49);
    bus_wr(32'h0003_0004, 8'h77);
    check_eq("stop_set", {31'd0, bus_if.program_stop}, 32'd1);
    bus_if.tx_ready = 1'b1;
    idle();
    check_eq("tx_seq1", {24'd0, bus_if.tx_data}, 32'h49);
    idle();
    check_eq("tx_seq2", {24'd0, bus_if.tx_data}, 32'h00);
    check_eq("tx_seq2_valid", {31'd0, bus_if.tx_valid}, 32'd1);
    idle();
    check_eq("tx_drained", {31'd0, bus_if.tx_valid}, 32'd0);
    bus_if.tx_ready = 1'b0;

    // TX backpressure: nearly-full flag, drop when full, push accepted alongside pop
    for (int i = 1; i <= 5; i++) bus_wr(32'h0003_0000, 8'(i));
    check_eq("iofull_5", {31'd0, bus_if.io_buffer_full}, 32'd0);
    bus_wr(32'h0003_0000, 8'h06);
    idle();
    check_eq("iofull_6", {31'd0, bus_if.io_buffer_full}, 32'd1);
    bus_wr(32'h0003_0000, 8'h07);
    bus_wr(32'h0003_0000, 8'h08);
    bus_wr(32'h0003_0000, 8'h09);
    check_eq("tx_full_head", {24'd0, bus_if.tx_data}, 32'h01);
    bus_if.tx_ready = 1'b1;
    bus_wr(32'h0003_0000, 8'h0A);
    for (int i = 0; i < 8; i++) begin
      check_eq("tx_drain", {24'd0, bus_if.tx_data}, {24'd0, exp_tx[i]});
      idle();
    end
    check_eq("tx_empty_after", {31'd0, bus_if.tx_valid}, 32'd0);
    check_eq("iofull_clear", {31'd0, bus_if.io_buffer_full}, 32'd0);
    bus_if.tx_ready = 1'b0;

    // RX path
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = 8'h31;
    idle();
    bus_if.rx_data  = 8'h32;
    idle();
    bus_if.rx_valid = 1'b0;
    bus_rd(32'h0003_0000);
    check_eq("rx_rd1", {24'd0, bus_if.mem_din}, 32'h31);
    bus_rd(32'h0003_0000);
    check_eq("rx_rd2", {24'd0, bus_if.mem_din}, 32'h32);
    bus_rd(32'h0003_0000);
    check_eq("rx_rd_empty", {24'd0, bus_if.mem_din}, 32'h00);
    bus_if.rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus_if.rx_data = 8'(8'h40 + i);
      idle();
    end
    bus_if.rx_valid = 1'b0;
    check_eq("rx_full", {31'd0, bus_if.rx_ready}, 32'd0);
    bus_rd(32'h0003_0000);
    check_eq("rx_full_head", {24'd0, bus_if.mem_din}, 32'h40);
    check_eq("rx_ready_again", {31'd0, bus_if.rx_ready}, 32'd1);

    // Cycle counter snapshot readout
    exp_cnt = cnt_model;
    for (int i = 0; i < 4; i++) begin
      bus_rd(32'h0003_0004 + 32'(i));
      snap_b[i] = bus_if.mem_din;
    end
    check_eq("cnt_snap", {snap_b[3], snap_b[2], snap_b[1], snap_b[0]}, exp_cnt);

    // Freeze with rdy_in low
    bus_rd(32'h0000_0011);
    bus_if.rdy_in   = 1'b0;
    bus_if.mem_wr   = 1'b1;
    bus_if.mem_a    = 32'h0000_0010;
    bus_if.mem_dout = 8'hEE;
    repeat (10) @(posedge clk_in);
    #1;
    check_eq("freeze_din", {24'd0, bus_if.mem_din}, 32'h5A);
    exp_cnt = cnt_model;
    bus_rd(32'h0003_0004);
    check_eq("freeze_cnt", {24'd0, bus_if.mem_din}, {24'd0, exp_cnt[7:0]});
    bus_rd(32'h0000_0010);
    check_eq("freeze_no_wr", {24'd0, bus_if.mem_din}, 32'h3C);

    // Asynchronous reset with both FIFOs occupied
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = 8'h50;
    idle();
    bus_if.rx_valid = 1'b0;
    check_eq("rx_refull", {31'd0, bus_if.rx_ready}, 32'd0);
    bus_wr(32'h0003_0000, 8'h77);
    bus_rd(32'h0000_0010);
    check_eq("pre_rst_tx", {31'd0, bus_if.tx_valid}, 32'd1);
    #2 rst_in = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk_in);
    rst_in    = 1'b1;
    cnt_model = 0;
    bus_rd(32'h0000_0010);
    check_eq("ram_kept", {24'd0, bus_if.mem_din}, 32'h3C);
    bus_rd(32'h0003_0004);
    check_eq("cnt_after_rst", {24'd0, bus_if.mem_din}, 32'h01);
    bus_rd(32'h0003_0000);
    check_eq("rx_flushed", {24'd0, bus_if.mem_din}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
